ex_stage_reg: RTL

EX_STAGE_REG -- requirements
Module: ex_stage_reg

---
 rtl/ex_stage_reg.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ex_stage_reg.sv
// rtl/ex_stage_reg.sv - EX stage ALU with registered EX/MEM outputs and sticky exception
//
// Purpose:
//    Computes the ALU operation selected by alu_ctl and registers the result
//    together with the destination index, write enable and valid bit. This
//    forms the EX/MEM pipeline register. Illegal operation codes, and signed
//    overflow when the trap is enabled, raise a sticky exception.
//
// Optional feature:
//    ALU_OVF_TRAP_EN - when defined, signed overflow on add/sub suppresses the
//    register write and raises exception code 10.
//
// Ports:
//    clk          in   1       rising-edge clock
//    reset        in   1       synchronous active-high reset
//    alu_ctl      in   4       ALU operation code
//    a            in   DATA_W  operand A
//    b            in   DATA_W  operand B
//    rd_in        in   REG_W   destination register index
//    regwrite_in  in   1       instruction writes the register file
//    valid_in     in   1       instruction present (0 = bubble)
//    stall        in   1       hold the EX/MEM register
//    flush        in   1       squash the instruction being captured
//    exc_clr      in   1       clear the sticky exception
//    result       out  DATA_W  registered ALU result
//    zero         out  1       registered (result == 0)
//    rd_out       out  REG_W   registered destination index
//    regwrite_out out  1       registered write enable, gated by exception
//    valid_out    out  1       EX/MEM slot holds an instruction
//    exc          out  1       sticky exception flag
//    exc_code     out  2       00 none, 01 illegal op, 10 overflow

module ex_stage_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        alu_ctl,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [REG_W-1:0]  rd_in,
   input  logic              regwrite_in,
   input  logic              valid_in,
   input  logic              stall,
   input  logic              flush,
   input  logic              exc_clr,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic [REG_W-1:0]  rd_out,
   output logic              regwrite_out,
   output logic              valid_out,
   output logic              exc,
   output logic [1:0]        exc_code
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;

   localparam logic [1:0] EXC_NONE = 2'b00;
   localparam logic [1:0] EXC_ILL  = 2'b01;
   localparam logic [1:0] EXC_OVF  = 2'b10;

   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_diff;
   logic [DATA_W-1:0] w_alu;
   logic              w_legal;
   logic              w_trap;

   logic [DATA_W-1:0] r_result;
   logic              r_zero;
   logic [REG_W-1:0]  r_rd;
   logic              r_regwrite;
   logic              r_valid;
   logic              r_exc;
   logic [1:0]        r_exc_code;

   assign w_sum  = a + b;
   assign w_diff = a - b;

   always_comb begin
      w_alu   = '0;
      w_legal = 1'b1;
      case (alu_ctl)
         OP_AND:  w_alu = a & b;
         OP_OR:   w_alu = a | b;
         OP_ADD:  w_alu = w_sum;
         OP_SUB:  w_alu = w_diff;
         OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         default: w_legal = 1'b0;
      endcase
   end

`ifdef ALU_OVF_TRAP_EN
   // Signed overflow: add of like signs, or sub of unlike signs, whose
   // result sign differs from operand A.
   logic w_ovf_add;
   logic w_ovf_sub;
   assign w_ovf_add = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1]  != a[DATA_W-1]);
   assign w_ovf_sub = (a[DATA_W-1] != b[DATA_W-1]) && (w_diff[DATA_W-1] != a[DATA_W-1]);
   assign w_trap    = ((alu_ctl == OP_ADD) && w_ovf_add) || ((alu_ctl == OP_SUB) && w_ovf_sub);
`else
   assign w_trap = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_result   <= '0;
         r_zero     <= 1'b1;
         r_rd       <= '0;
         r_regwrite <= 1'b0;
         r_valid    <= 1'b0;
         r_exc      <= 1'b0;
         r_exc_code <= EXC_NONE;
      end else if (flush) begin
         // Squashed slot; a flushed illegal op must not raise an exception.
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
      end else if (!stall) begin
         if (!valid_in) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            if (exc_clr) begin
               r_exc      <= 1'b0;
               r_exc_code <= EXC_NONE;
            end
         end else if (!w_legal) begin
            // New exception capture wins over a simultaneous exc_clr.
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_rd       <= rd_in;
            r_regwrite <= 1'b0;
            r_valid    <= 1'b1;
            r_exc      <= 1'b1;
            r_exc_code <= EXC_ILL;
         end else begin
            r_result <= w_alu;
            r_zero   <= (w_alu == '0);
            r_rd     <= rd_in;
            r_valid  <= 1'b1;
            if (w_trap) begin
               r_regwrite <= 1'b0;
               r_exc      <= 1'b1;
               r_exc_code <= EXC_OVF;
            end else begin
               r_regwrite <= regwrite_in;
               if (exc_clr) begin
                  r_exc      <= 1'b0;
                  r_exc_code <= EXC_NONE;
               end
            end
         end
      end
   end

   assign result       = r_result;
   assign zero         = r_zero;
   assign rd_out       = r_rd;
   assign regwrite_out = r_regwrite;
   assign valid_out    = r_valid;
   assign exc          = r_exc;
   assign exc_code     = r_exc_code;

endmodule
